// File: rtl/sig_check.sv
// Incrementing-word checker: acquires lock on a counting stream, counts mismatches and wraps.
// Optional first-mismatch capture enabled by defining SIG_CHECK_DIAG_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no sample seen since reset; first valid sample seeds exp
// S_ACQUIRE | counting consecutive matches toward LOCK_LEN
// S_LOCKED  | tracking stream; mismatches pulse err, wraps counted
// S_DONE    | NUM_WRAPS reached; everything frozen until rst
module sig_check #(
  parameter int WIDTH     = 4,
  parameter int LOCK_LEN  = 2,
  parameter int LOSS_LEN  = 3,
  parameter int NUM_WRAPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             a_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count,
`ifdef SIG_CHECK_DIAG_EN
  output logic [WIDTH-1:0] first_got,
  output logic [WIDTH-1:0] first_exp,
  output logic             diag_valid,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [3:0]       LOCK_LEN_C  = 4'(LOCK_LEN);
  localparam logic [3:0]       LOSS_LEN_C  = 4'(LOSS_LEN);
  localparam logic [7:0]       NUM_WRAPS_C = 8'(NUM_WRAPS);
  localparam logic [WIDTH-1:0] MAX_VAL     = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [7:0]       wrap_count_q, wrap_count_d;
  logic             done_q, done_d;
`ifdef SIG_CHECK_DIAG_EN
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic             diag_valid_q, diag_valid_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      exp_q        <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      done_q       <= 1'b0;
`ifdef SIG_CHECK_DIAG_EN
      first_got_q  <= '0;
      first_exp_q  <= '0;
      diag_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      done_q       <= done_d;
`ifdef SIG_CHECK_DIAG_EN
      first_got_q  <= first_got_d;
      first_exp_q  <= first_exp_d;
      diag_valid_q <= diag_valid_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    done_d       = done_q;
`ifdef SIG_CHECK_DIAG_EN
    first_got_d  = first_got_q;
    first_exp_d  = first_exp_q;
    diag_valid_d = diag_valid_q;
`endif
    if (a_valid) begin
      unique case (state_q)
        S_IDLE: begin
          exp_d       = A + 1'b1;
          match_cnt_d = 4'd1;
          miss_cnt_d  = 4'd0;
          state_d     = (LOCK_LEN_C <= 4'd1) ? S_LOCKED : S_ACQUIRE;
        end
        S_ACQUIRE: begin
          if (A == exp_q) begin
            exp_d       = exp_q + 1'b1;
            match_cnt_d = match_cnt_q + 4'd1;
            // >= so LOCK_LEN==1 can still relock after a reseed to count 1
            if (match_cnt_d >= LOCK_LEN_C) begin
              state_d    = S_LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else begin
            exp_d       = A + 1'b1;
            match_cnt_d = 4'd1;
          end
        end
        S_LOCKED: begin
          if (A == exp_q) begin
            exp_d      = exp_q + 1'b1;
            miss_cnt_d = 4'd0;
            if (A == MAX_VAL) begin
              if (wrap_count_q != 8'hFF) wrap_count_d = wrap_count_q + 8'd1;
              if (wrap_count_d >= NUM_WRAPS_C) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
`ifdef SIG_CHECK_DIAG_EN
            if (!diag_valid_q) begin
              first_got_d  = A;
              first_exp_d  = exp_q;
              diag_valid_d = 1'b1;
            end
`endif
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d >= LOSS_LEN_C) begin
              state_d     = S_ACQUIRE;
              exp_d       = A + 1'b1;
              match_cnt_d = 4'd1;
              miss_cnt_d  = 4'd0;
            end else begin
              exp_d = exp_q + 1'b1;
            end
          end
        end
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign locked     = (state_q == S_LOCKED);
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign done       = done_q;
`ifdef SIG_CHECK_DIAG_EN
  assign first_got  = first_got_q;
  assign first_exp  = first_exp_q;
  assign diag_valid = diag_valid_q;
`endif

endmodule

// File: tb/tb_sig_check.sv
// Bench for sig_check: behavioural stream model checked every cycle, plus directed literal checks.
// Diag outputs are connected and checked when SIG_CHECK_DIAG_EN is defined.
module tb_sig_check;

  localparam int WIDTH     = 4;
  localparam int LOCK_LEN  = 2;
  localparam int LOSS_LEN  = 3;
  localparam int NUM_WRAPS = 1;
  localparam int MODV      = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic             a_valid;
  logic             locked, err, done;
  logic [7:0]       err_count, wrap_count;
`ifdef SIG_CHECK_DIAG_EN
  logic [WIDTH-1:0] first_got, first_exp;
  logic             diag_valid;
`endif

  sig_check #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .NUM_WRAPS(NUM_WRAPS)) dut (
    .clk(clk), .rst(rst), .A(A), .a_valid(a_valid),
    .locked(locked), .err(err), .err_count(err_count), .wrap_count(wrap_count),
`ifdef SIG_CHECK_DIAG_EN
    .first_got(first_got), .first_exp(first_exp), .diag_valid(diag_valid),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Model: mode 0 waiting for first sample, 1 acquiring, 2 locked, 3 finished.
  int m_mode, m_exp, m_run, m_miss, m_errs, m_wraps;
  bit m_err, m_done;
  int m_fg, m_fe;
  bit m_dv;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_errs = 0; m_wraps = 0;
      m_err = 0; m_done = 0; m_fg = 0; m_fe = 0; m_dv = 0;
    end else begin
      int a;
      a = int'(A);
      m_err = 0;
      if (a_valid) begin
        if (m_mode == 0) begin
          m_exp = (a + 1) % MODV; m_run = 1; m_miss = 0;
          m_mode = (LOCK_LEN <= 1) ? 2 : 1;
        end else if (m_mode == 1) begin
          if (a == m_exp) begin
            m_exp = (m_exp + 1) % MODV; m_run++;
            if (m_run >= LOCK_LEN) begin m_mode = 2; m_miss = 0; end
          end else begin
            m_exp = (a + 1) % MODV; m_run = 1;
          end
        end else if (m_mode == 2) begin
          if (a == m_exp) begin
            m_exp = (m_exp + 1) % MODV; m_miss = 0;
            if (a == MODV - 1) begin
              if (m_wraps < 255) m_wraps++;
              if (m_wraps >= NUM_WRAPS) begin m_mode = 3; m_done = 1; end
            end
          end else begin
            m_err = 1;
            if (m_errs < 255) m_errs++;
            if (!m_dv) begin m_fg = a; m_fe = m_exp; m_dv = 1; end
            m_miss++;
            if (m_miss >= LOSS_LEN) begin
              m_mode = 1; m_exp = (a + 1) % MODV; m_run = 1; m_miss = 0;
            end else begin
              m_exp = (m_exp + 1) % MODV;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", 32'(locked), 32'(m_mode == 2));
      chk("err", 32'(err), 32'(m_err));
      chk("err_count", 32'(err_count), 32'(m_errs));
      chk("wrap_count", 32'(wrap_count), 32'(m_wraps));
      chk("done", 32'(done), 32'(m_done));
`ifdef SIG_CHECK_DIAG_EN
      chk("diag_valid", 32'(diag_valid), 32'(m_dv));
      chk("first_got", 32'(first_got), 32'(m_fg));
      chk("first_exp", 32'(first_exp), 32'(m_fe));
`endif
    end
  end

  task automatic send(input int a, input bit v);
    rst = 1'b0; A = WIDTH'(a); a_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int a, input bit v);
    rst = 1'b1; A = WIDTH'(a); a_valid = v;
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_wrap_count"}, 32'(wrap_count), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int nxt;
    rst = 1'b1; A = '0; a_valid = 1'b0;
    do_reset(0, 0);
    cmp_en = 1;
    chk_all_zero("reset");

    // plain counting stream: lock after sample 1, done after sample 15
    for (int i = 0; i < 16; i++) begin
      send(i, 1);
      if (i == 0) chk("cnt_locked_s0", 32'(locked), 0);
      if (i == 1) chk("cnt_locked_s1", 32'(locked), 1);
      if (i == 14) chk("cnt_done_s14", 32'(done), 0);
    end
    chk("cnt_done", 32'(done), 1);
    chk("cnt_wrap", 32'(wrap_count), 1);
    chk("cnt_errs", 32'(err_count), 0);
    chk("cnt_locked_done", 32'(locked), 0);
    send(3, 1);
    chk("cnt_done_hold", 32'(done), 1);
    chk("cnt_errs_hold", 32'(err_count), 0);

    // single glitch: ...,5,6,9,8
    do_reset(0, 0);
    for (int i = 0; i < 7; i++) send(i, 1);
    send(9, 1);
    chk("glitch_err", 32'(err), 1);
    chk("glitch_cnt", 32'(err_count), 1);
    chk("glitch_locked", 32'(locked), 1);
    send(8, 1);
    chk("glitch_err_after", 32'(err), 0);
    chk("glitch_locked_after", 32'(locked), 1);

    // loss of lock: 12,12,12 where 7,8,9 expected, then relock on 13,14
    do_reset(0, 0);
    for (int i = 0; i < 7; i++) send(i, 1);
    for (int k = 0; k < 3; k++) begin
      send(12, 1);
      chk("loss_err", 32'(err), 1);
      if (k < 2) chk("loss_still_locked", 32'(locked), 1);
    end
    chk("loss_locked", 32'(locked), 0);
    chk("loss_cnt", 32'(err_count), 3);
    send(13, 1);
    chk("relock_13", 32'(locked), 1);
    send(14, 1);
    chk("relock_14", 32'(locked), 1);
    chk("relock_err", 32'(err), 0);

    // a_valid toggling: identical results, done on the 16th valid sample
    do_reset(0, 0);
    nxt = 0;
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) begin send(nxt, 1); nxt++; end
      else send(int'($urandom_range(0, MODV - 1)), 0);
      if (k == 29) chk("tog_done_early", 32'(done), 0);
    end
    chk("tog_done", 32'(done), 1);
    chk("tog_wrap", 32'(wrap_count), 1);
    chk("tog_errs", 32'(err_count), 0);

    // reset mid-lock with err_count=2 beats a valid sample
    do_reset(0, 0);
    for (int i = 0; i < 5; i++) send(i, 1);
    send(9, 1);
    send(6, 1);
    send(2, 1);
    chk("mid_errs", 32'(err_count), 2);
    chk("mid_locked", 32'(locked), 1);
    do_reset(8, 1);
    chk_all_zero("midrst");
    send(3, 1);
    send(4, 1);
    chk("midrst_relock", 32'(locked), 1);

`ifdef SIG_CHECK_DIAG_EN
    do_reset(0, 0);
    for (int i = 0; i < 7; i++) send(i, 1);
    send(9, 1);
    chk("diag_got", 32'(first_got), 9);
    chk("diag_exp", 32'(first_exp), 7);
    chk("diag_v", 32'(diag_valid), 1);
    send(8, 1); send(9, 1); send(10, 1);
    send(3, 1);
    chk("diag_got_keep", 32'(first_got), 9);
    chk("diag_exp_keep", 32'(first_exp), 7);
`endif

    // randomized stream, mostly following the expected count
    do_reset(0, 0);
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2 || (m_done && r < 15)) begin
        do_reset(int'($urandom_range(0, MODV - 1)), 1'($urandom_range(0, 1)));
      end else begin
        int a;
        if ($urandom_range(0, 99) < 85) a = m_exp;
        else a = int'($urandom_range(0, MODV - 1));
        send(a, $urandom_range(0, 99) < 70);
      end
    end

    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
